// File: rtl/odesa_pkg.sv
// ---------------------------------------------------------------------------
// odesa_pkg
// Shared definitions for the trace / neuron / winner blocks of the SNN
// classifier: width helpers and the scan FSM state encoding.
//   f_clog2(v)       : ceil(log2(v)), never less than 1 (usable as a width)
//   f_tw(w, n)       : trace width = integer bits + fractional bits
//   f_aw(tw, ww, n)  : dot-product width, sized so N products cannot overflow
//   ST_IDLE/ACC/CMP  : scan FSM states
// ---------------------------------------------------------------------------
package odesa_pkg;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_ACC  = 2'd1;
    localparam logic [1:0] ST_CMP  = 2'd2;

    function automatic int f_clog2(input int v);
        int r;
        r = 0;
        for (int x = v - 1; x > 0; x = x >> 1) begin
            r = r + 1;
        end
        return (r < 1) ? 1 : r;
    endfunction

    function automatic int f_tw(input int width, input int nbit);
        return width + nbit;
    endfunction

    function automatic int f_aw(input int tw, input int wwidth, input int ninputs);
        return tw + wwidth + f_clog2(ninputs);
    endfunction

endpackage

// File: rtl/trace_neuron_if.sv
// ---------------------------------------------------------------------------
// trace_neuron_if
// Scan-control and trace-read signals of the trace_neuron block.
//   i_start     : start one scan (single-cycle pulse)
//   o_sel       : trace index requested this cycle
//   i_trace     : trace value for the index requested in the previous cycle
//   o_busy      : scan in progress
//   o_done      : one-cycle pulse when a scan finishes
//   o_spike     : one-cycle pulse coincident with o_done when the neuron fired
//   o_potential : last completed dot-product value
// Modports: slave = the neuron, master = its driver (controller / bench).
// ---------------------------------------------------------------------------
interface trace_neuron_if #(
    parameter int p_sw = 4,
    parameter int p_tw = 16,
    parameter int p_aw = 28
);
    logic            i_start;
    logic [p_sw-1:0] o_sel;
    logic [p_tw-1:0] i_trace;
    logic            o_busy;
    logic            o_done;
    logic            o_spike;
    logic [p_aw-1:0] o_potential;

    modport slave (
        input  i_start, i_trace,
        output o_sel, o_busy, o_done, o_spike, o_potential
    );

    modport master (
        output i_start, i_trace,
        input  o_sel, o_busy, o_done, o_spike, o_potential
    );
endinterface

// File: rtl/trace_mac.sv
// ---------------------------------------------------------------------------
// trace_mac
// Registered unsigned multiply-accumulate: acc <= acc + a*b when enabled,
// acc <= 0 when cleared (clear wins over enable).
//   i_clk   : clock, rising edge
//   i_rst_n : synchronous reset, active-low
//   i_clr   : clear accumulator
//   i_en    : accumulate this cycle
//   i_a     : trace operand (p_tw bits)
//   i_b     : weight operand (p_ww bits)
//   o_acc   : accumulator (p_aw bits)
// ---------------------------------------------------------------------------
module trace_mac #(
    parameter int p_tw = 16,
    parameter int p_ww = 8,
    parameter int p_aw = 28
) (
    input  logic            i_clk,
    input  logic            i_rst_n,
    input  logic            i_clr,
    input  logic            i_en,
    input  logic [p_tw-1:0] i_a,
    input  logic [p_ww-1:0] i_b,
    output logic [p_aw-1:0] o_acc
);
    localparam int PW = p_tw + p_ww;

    logic [PW-1:0]   w_prod;
    logic [p_aw-1:0] r_acc;

    assign w_prod = PW'(i_a) * PW'(i_b);

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_acc <= '0;
        end else if (i_clr) begin
            r_acc <= '0;
        end else if (i_en) begin
            r_acc <= r_acc + p_aw'(w_prod);
        end
    end

    assign o_acc = r_acc;
endmodule

// File: rtl/trace_neuron.sv
// ---------------------------------------------------------------------------
// trace_neuron
// On a start pulse, scans p_ninputs traces through a select/read port with a
// one-cycle read latency, accumulates sum(trace[k]*w[k]), compares it with the
// threshold and emits a one-cycle spike together with done, then holds off new
// scans for p_refrac cycles after a spike.
//   i_clk        : clock, rising edge
//   i_rst_n      : synchronous reset, active-low
//   bus          : trace_neuron_if.slave (start, sel, trace, busy, done,
//                  spike, potential)
//   i_syn_weight : flat weight vector, entry k at [k*p_wwidth +: p_wwidth]
//   i_threshold  : firing threshold, unsigned
// Optional feature: define TRACE_NEURON_THRESH_ADAPT_EN to add an adaptive
// threshold offset (raised by p_thr_step on each spike, decays by 1 on each
// non-firing scan).
// ---------------------------------------------------------------------------
module trace_neuron
    import odesa_pkg::*;
#(
    parameter int p_width    = 8,
    parameter int p_nbit     = 8,
    parameter int p_ninputs  = 16,
    parameter int p_wwidth   = 8,
    parameter int p_refrac   = 4,
    parameter int p_thr_step = 64,
    localparam int TW = f_tw(p_width, p_nbit),
    localparam int AW = f_aw(TW, p_wwidth, p_ninputs)
) (
    input  logic                          i_clk,
    input  logic                          i_rst_n,
    trace_neuron_if.slave                 bus,
    input  logic [p_ninputs*p_wwidth-1:0] i_syn_weight,
    input  logic [AW-1:0]                 i_threshold
);
    localparam int SW = f_clog2(p_ninputs);
    localparam int KW = f_clog2(p_ninputs + 1);   // k runs 0..N inclusive
    localparam int RW = f_clog2(p_refrac + 1);

    logic [1:0]    r_state;
    logic [KW-1:0] r_k;
    logic [SW-1:0] r_sel;
    logic          r_done;
    logic          r_spike;
    logic [AW-1:0] r_potential;
    logic [RW-1:0] r_refrac;

    logic [p_wwidth-1:0] w_weights [p_ninputs];
    logic [SW-1:0]       w_widx;
    logic [p_wwidth-1:0] w_weight;
    logic                w_start_ok;
    logic                w_mac_en;
    logic                w_last_k;
    logic [AW-1:0]       w_acc;
    logic [AW-1:0]       w_thr_eff;
    logic                w_fire;

    genvar gi;
    generate
        for (gi = 0; gi < p_ninputs; gi = gi + 1) begin : g_wunpack
            assign w_weights[gi] = i_syn_weight[gi*p_wwidth +: p_wwidth];
        end
    endgenerate

    // The trace arriving now belongs to the index selected last cycle, so
    // step k pairs with weight k-1.
    assign w_widx     = SW'(r_k - KW'(1));
    assign w_weight   = w_weights[w_widx];
    assign w_start_ok = (r_state == ST_IDLE) && bus.i_start && (r_refrac == '0);
    assign w_mac_en   = (r_state == ST_ACC) && (r_k != '0);
    assign w_last_k   = (r_k == KW'(p_ninputs));

    trace_mac #(
        .p_tw (TW),
        .p_ww (p_wwidth),
        .p_aw (AW)
    ) u_mac (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_clr   (w_start_ok),
        .i_en    (w_mac_en),
        .i_a     (bus.i_trace),
        .i_b     (w_weight),
        .o_acc   (w_acc)
    );

`ifdef TRACE_NEURON_THRESH_ADAPT_EN
    logic [AW-1:0] r_thr_adj;
    logic [AW:0]   w_thr_sum;
    logic [AW:0]   w_adj_sum;
    logic [AW-1:0] w_adj_inc;

    // Both additions saturate at all-ones rather than wrapping.
    assign w_thr_sum = {1'b0, i_threshold} + {1'b0, r_thr_adj};
    assign w_thr_eff = w_thr_sum[AW] ? '1 : w_thr_sum[AW-1:0];
    assign w_adj_sum = {1'b0, r_thr_adj} + (AW+1)'(p_thr_step);
    assign w_adj_inc = w_adj_sum[AW] ? '1 : w_adj_sum[AW-1:0];

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_thr_adj <= '0;
        end else if (r_state == ST_CMP) begin
            if (w_fire) begin
                r_thr_adj <= w_adj_inc;
            end else if (r_thr_adj != '0) begin
                r_thr_adj <= r_thr_adj - AW'(1);
            end
        end
    end
`else
    assign w_thr_eff = i_threshold;
`endif

    assign w_fire = (w_acc >= w_thr_eff);

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_state     <= ST_IDLE;
            r_k         <= '0;
            r_sel       <= '0;
            r_done      <= 1'b0;
            r_spike     <= 1'b0;
            r_potential <= '0;
            r_refrac    <= '0;
        end else begin
            r_done  <= 1'b0;
            r_spike <= 1'b0;
            // A new spike below overrides this decrement.
            if (r_refrac != '0) begin
                r_refrac <= r_refrac - RW'(1);
            end
            case (r_state)
                ST_IDLE: begin
                    if (w_start_ok) begin
                        r_state <= ST_ACC;
                        r_k     <= '0;
                        r_sel   <= '0;
                    end
                end
                ST_ACC: begin
                    if (w_last_k) begin
                        r_state <= ST_CMP;
                    end else begin
                        r_k <= r_k + KW'(1);
                        // Select holds at N-1 during the final drain step.
                        if (r_k < KW'(p_ninputs - 1)) begin
                            r_sel <= SW'(r_k + KW'(1));
                        end
                    end
                end
                ST_CMP: begin
                    r_potential <= w_acc;
                    r_done      <= 1'b1;
                    r_spike     <= w_fire;
                    if (w_fire) begin
                        r_refrac <= RW'(p_refrac);
                    end
                    r_state <= ST_IDLE;
                    r_sel   <= '0;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.o_sel       = r_sel;
    assign bus.o_busy      = (r_state != ST_IDLE);
    assign bus.o_done      = r_done;
    assign bus.o_spike     = r_spike;
    assign bus.o_potential = r_potential;
endmodule
